// File: rtl/vid_timing_gen.sv
// Raster timing generator: sync/back-porch/active/front-porch counters with registered strobes.
// Define VTG_PATTERN_EN to drive 8 vertical colour bars on vid_data_out.
module vid_timing_gen #(
    parameter logic [11:0] H_ACTIVE = 12'd1920,
    parameter logic [11:0] H_FP     = 12'd88,
    parameter logic [11:0] H_SYNC   = 12'd44,
    parameter logic [11:0] H_BP     = 12'd148,
    parameter logic [11:0] V_ACTIVE = 12'd1080,
    parameter logic [11:0] V_FP     = 12'd4,
    parameter logic [11:0] V_SYNC   = 12'd5,
    parameter logic [11:0] V_BP     = 12'd36
) (
    input  logic        mpt_clk,
    input  logic        mpt_arst,
    input  logic        vid_en,
    output logic        vid_vs_out,
    output logic        vid_hs_out,
    output logic        vid_de_out,
    output logic        vid_sof,
    output logic [11:0] vid_line,
    output logic        vid_locked,
    output logic [23:0] vid_data_out
);

    // Totals may be exactly 4096, so the "last" values are formed modulo 2^12.
    localparam logic [11:0] H_LAST     = H_SYNC + H_BP + H_ACTIVE + H_FP - 12'd1;
    localparam logic [11:0] V_LAST     = V_SYNC + V_BP + V_ACTIVE + V_FP - 12'd1;
    localparam logic [11:0] H_DE_START = H_SYNC + H_BP;
    localparam logic [11:0] V_DE_START = V_SYNC + V_BP;
    localparam logic [12:0] H_DE_END   = {1'b0, H_DE_START} + {1'b0, H_ACTIVE};
    localparam logic [12:0] V_DE_END   = {1'b0, V_DE_START} + {1'b0, V_ACTIVE};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        frame_done_q, frame_done_d;

    logic        run;
    logic        h_last, v_last;
    logic        hs_d, vs_d, de_d, sof_d;
    logic [11:0] line_d;

    assign run    = (state_q == StRun);
    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    always_comb begin
        state_d      = state_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_done_d = frame_done_q;
        unique case (state_q)
            StIdle: begin
                h_cnt_d      = 12'd0;
                v_cnt_d      = 12'd0;
                frame_done_d = 1'b0;
                if (vid_en) state_d = StRun;
            end
            StRun: begin
                if (!vid_en) begin
                    // Truncate immediately; the next run restarts at start of frame.
                    state_d      = StIdle;
                    h_cnt_d      = 12'd0;
                    v_cnt_d      = 12'd0;
                    frame_done_d = 1'b0;
                end else if (h_last) begin
                    h_cnt_d = 12'd0;
                    if (v_last) begin
                        v_cnt_d      = 12'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        v_cnt_d = v_cnt_q + 12'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 12'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hs_d   = run && (h_cnt_q < H_SYNC);
        vs_d   = run && (v_cnt_q < V_SYNC);
        de_d   = run && (h_cnt_q >= H_DE_START) && ({1'b0, h_cnt_q} < H_DE_END)
                     && (v_cnt_q >= V_DE_START) && ({1'b0, v_cnt_q} < V_DE_END);
        sof_d  = run && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        line_d = v_cnt_q - V_DE_START;
    end

    always_ff @(posedge mpt_clk) begin
        if (mpt_arst) begin
            state_q      <= StIdle;
            h_cnt_q      <= 12'd0;
            v_cnt_q      <= 12'd0;
            frame_done_q <= 1'b0;
            vid_hs_out   <= 1'b0;
            vid_vs_out   <= 1'b0;
            vid_de_out   <= 1'b0;
            vid_sof      <= 1'b0;
            vid_line     <= 12'd0;
            vid_locked   <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_done_q <= frame_done_d;
            vid_hs_out   <= hs_d;
            vid_vs_out   <= vs_d;
            vid_de_out   <= de_d;
            vid_sof      <= sof_d;
            vid_locked   <= frame_done_q;
            if (de_d) vid_line <= line_d;
        end
    end

`ifdef VTG_PATTERN_EN
    // Remainder pixels beyond 8*BAR_W are clamped into the last bar.
    localparam logic [11:0] BAR_W = (H_ACTIVE >= 12'd8) ? (H_ACTIVE >> 3) : 12'd1;

    logic [11:0] px;
    logic [11:0] bar;
    logic [2:0]  bar_idx;
    logic [23:0] colour;
    logic [23:0] data_d;

    always_comb begin
        px      = h_cnt_q - H_DE_START;
        bar     = px / BAR_W;
        bar_idx = (bar > 12'd7) ? 3'd7 : bar[2:0];
        unique case (bar_idx)
            3'd0:    colour = 24'hFFFFFF;
            3'd1:    colour = 24'hFFFF00;
            3'd2:    colour = 24'h00FFFF;
            3'd3:    colour = 24'h00FF00;
            3'd4:    colour = 24'hFF00FF;
            3'd5:    colour = 24'hFF0000;
            3'd6:    colour = 24'h0000FF;
            default: colour = 24'h000000;
        endcase
        data_d = de_d ? colour : 24'h0;
    end

    always_ff @(posedge mpt_clk) begin
        if (mpt_arst) vid_data_out <= 24'h0;
        else          vid_data_out <= data_d;
    end
`else
    assign vid_data_out = 24'h0;
`endif

endmodule

// File: doc/vid_timing_gen.md
# vid_timing_gen

Video timing generator that produces the `vid_vs`/`vid_hs`/`vid_de` raster consumed by the MPT line-counting and remap control logic.
- Free-running horizontal and vertical counters are built from parameterised porch, sync and active widths.
- Registered sync/enable strobes, a start-of-frame pulse and a lock flag are output.
- Sits at the source end of the video path; also used as the bench stimulus for downstream remap blocks.

## Interface
- `H_ACTIVE`, 12'd1920, active pixels per line
- `H_FP`, 12'd88, horizontal front porch (clocks)
- `H_SYNC`, 12'd44, horizontal sync width (clocks)
- `H_BP`, 12'd148, horizontal back porch (clocks)
- `V_ACTIVE`, 12'd1080, active lines per frame
- `V_FP`, 12'd4, vertical front porch (lines)
- `V_SYNC`, 12'd5, vertical sync width (lines)
- `V_BP`, 12'd36, vertical back porch (lines)
- `mpt_clk`  in  1  pixel clock; one clock, all logic on rising edge
- `mpt_arst`  in  1  reset, synchronous, active-high
- `vid_en`  in  1  run enable; low holds generator idle
- `vid_vs_out`  out  1  vertical sync, active-high
- `vid_hs_out`  out  1  horizontal sync, active-high
- `vid_de_out`  out  1  data enable, active-high
- `vid_sof`  out  1  one-clock start-of-frame pulse
- `vid_line`  out  12  active line index, 0..V_ACTIVE-1, valid while `vid_de_out`=1
- `vid_locked`  out  1  high once one complete frame has been emitted
- `vid_data_out`  out  24  pixel data (see Configuration)

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP. Both totals must be ≤ 4096, so 12-bit counters never overflow.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments on `h_cnt` wrap and wraps to 0 after V_TOTAL-1.
- Line order is sync, back porch, active, front porch, in both axes.
- hs = (h_cnt < H_SYNC).
- vs = (v_cnt < V_SYNC). vs edges therefore align with h_cnt=0.
- de = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- sof = (h_cnt==0 && v_cnt==0).
- `vid_line` = v_cnt-(V_SYNC+V_BP), registered with de. It holds its last value outside active lines.
- States: IDLE, RUN.
  - IDLE → RUN when `vid_en`=1.
  - RUN → IDLE when `vid_en`=0.
  - In IDLE, counters are held at 0 and all strobes are low.
- `vid_locked`:
  - Set on the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0) in RUN.
  - Cleared when the block enters IDLE or on reset.
- Reset mid-frame: counters go to 0 and the state goes to IDLE. The next frame after reset always starts at sof, never mid-frame.
- `vid_en` falling mid-frame: the frame is truncated with no completion of the current line. The outputs fall low on the next clock.

## Timing
- Reset values:
  - All outputs 0, including `vid_line`=0 and `vid_data_out`=0.
  - State is IDLE and counters are 0.
- Outputs are registered, with one clock of latency from counter state.
- `vid_en` rising edge at cycle N:
  - State is RUN at N+1 with counters at (0,0).
  - `vid_sof`, `vid_vs_out` and `vid_hs_out` are high at N+2.
- `vid_sof` is exactly one clock wide, once per V_TOTAL×H_TOTAL clocks.
- `vid_de_out` rises exactly once per active line. There are exactly V_ACTIVE rising edges between successive vs rising edges, so a downstream line counter reads V_ACTIVE.
- `vid_en` falling edge at cycle N:
  - State is IDLE at N+1.
  - All strobes and `vid_locked` are low at N+2.

## Configuration
- `VTG_PATTERN_EN` defined:
  - `vid_data_out` carries 8 vertical colour bars, each H_ACTIVE/8 pixels wide (integer division). Remainder pixels extend the last bar.
  - Bar order is white, yellow, cyan, green, magenta, red, blue, black, with 24'hFFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Data is registered in the same stage as de, so it is aligned with `vid_de_out`.
  - Outside de, data is 0.
- `VTG_PATTERN_EN` undefined: `vid_data_out` is tied to 24'h0 and no pattern logic is synthesised.

## Test plan
All scenarios use small parameters unless noted: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); 98 clocks per frame.
- Reset, then `vid_en`=1 at cycle 0:
  - `vid_sof` pulses at cycles 2, 100, 198.
  - `vid_hs_out` is high for 2 of every 14 clocks.
  - `vid_vs_out` is high for 14 clocks starting at cycle 2.
- Same run: `vid_de_out` is high 8 clocks per line on exactly 4 lines per frame.
  - The first de of a frame occurs at cycle 2+2×14+4=34.
  - `vid_line` reads 0,1,2,3 on successive active lines.
- Lock: `vid_locked` is 0 through cycle 99 and 1 from cycle 100 onward.
- `vid_en` dropped at cycle 60:
  - All strobes and `vid_locked` are 0 from cycle 62.
  - Re-enabling at cycle 80 gives `vid_sof` at cycle 82.
- `mpt_arst` pulsed mid-line at cycle 150 with `vid_en` held high:
  - Outputs are 0 at cycle 151.
  - Counters restart at (0,0) at cycle 152 and `vid_sof` is at cycle 153.
- With `VTG_PATTERN_EN` defined:
  - Pixel k of each active line equals bar (k/1); pixel 0 = FFFFFF, pixel 7 = 000000.
  - `vid_data_out` is 0 whenever `vid_de_out`=0.
